// File: rtl/axis_stream_sink_if.sv
// AXI4-Stream bundle between the streaming master and axis_stream_sink.
// The sink uses the slave modport; a traffic source uses the master modport.
interface axis_stream_sink_if #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32
);
    logic                                TREADY;
    logic [C_S_AXIS_TDATA_WIDTH-1:0]     TDATA;
    logic [(C_S_AXIS_TDATA_WIDTH/8)-1:0] TSTRB;
    logic                                TLAST;
    logic                                TVALID;

    modport slave  (output TREADY, input  TDATA, TSTRB, TLAST, TVALID);
    modport master (input  TREADY, output TDATA, TSTRB, TLAST, TVALID);
endinterface

// File: rtl/axis_stream_sink.sv
// AXI4-Stream slave that captures one frame into a local buffer and hands it to a pop port.
// Define AXIS_SINK_SEQ_CHECK_EN to compare beats against the 1,2,3,... test pattern.
module axis_stream_sink #(
    parameter int C_S_AXIS_TDATA_WIDTH  = 32,
    parameter int NUMBER_OF_INPUT_WORDS = 8
) (
    input  logic                                           S_AXIS_ACLK,
    input  logic                                           S_AXIS_ARESETN,
    axis_stream_sink_if.slave                              axis,
    input  logic                                           rd_en,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]                rd_data,
    output logic                                           rd_valid,
    output logic                                           frame_done,
    output logic [$clog2(NUMBER_OF_INPUT_WORDS+1)-1:0]     frame_len,
    output logic                                           trunc_err,
    output logic                                           seq_err
);
    localparam int DW = C_S_AXIS_TDATA_WIDTH;
    localparam int N  = NUMBER_OF_INPUT_WORDS;
    localparam int LW = $clog2(N + 1);
    localparam int AW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] WRITE_FIFO  = 2'd1;
    localparam logic [1:0] FRAME_READY = 2'd2;

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic          tready_r;
    logic          frame_done_r;
    logic          rd_valid_r;
    logic          trunc_err_r;
    logic          seq_err_r;
    logic [DW-1:0] rd_data_r;
    logic [LW-1:0] wr_ptr_r;
    logic [LW-1:0] rd_ptr_r;
    logic [LW-1:0] frame_len_r;
    logic [DW-1:0] mem_r [N];

    logic accept_s;
    logic close_s;
    logic pop_s;
    logic last_pop_s;
    logic seq_bad_s;
    logic unused_s;

    // Byte qualifiers carry no meaning here: full words are always stored.
    assign unused_s   = ^axis.TSTRB;

    assign accept_s   = tready_r && axis.TVALID;
    assign close_s    = accept_s && (axis.TLAST || (wr_ptr_r == LW'(N - 1)));
    assign pop_s      = (state_r == FRAME_READY) && rd_en;
    assign last_pop_s = pop_s && (rd_ptr_r == (frame_len_r - LW'(1)));

`ifdef AXIS_SINK_SEQ_CHECK_EN
    assign seq_bad_s  = accept_s && (axis.TDATA != DW'(wr_ptr_r + LW'(1)));
`else
    assign seq_bad_s  = 1'b0;
`endif

    // Next-state decode for the capture/drain sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                state_nxt_s = WRITE_FIFO;
            end
            WRITE_FIFO: begin
                if (close_s) begin
                    state_nxt_s = FRAME_READY;
                end else begin
                    state_nxt_s = WRITE_FIFO;
                end
            end
            FRAME_READY: begin
                if (last_pop_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = FRAME_READY;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, pointers, status flags and the registered read port.
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state_r      <= IDLE;
            tready_r     <= 1'b0;
            frame_done_r <= 1'b0;
            rd_valid_r   <= 1'b0;
            rd_data_r    <= '0;
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            frame_len_r  <= '0;
            trunc_err_r  <= 1'b0;
            seq_err_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            // Ready/done follow the registered state only, never TVALID/TLAST combinationally.
            tready_r     <= (state_nxt_s == WRITE_FIFO);
            frame_done_r <= (state_nxt_s == FRAME_READY);
            rd_valid_r   <= pop_s;
            case (state_r)
                IDLE: begin
                    wr_ptr_r    <= '0;
                    rd_ptr_r    <= '0;
                    frame_len_r <= '0;
                    trunc_err_r <= 1'b0;
                    seq_err_r   <= 1'b0;
                end
                WRITE_FIFO: begin
                    if (accept_s) begin
                        wr_ptr_r <= wr_ptr_r + LW'(1);
                    end else begin
                        wr_ptr_r <= wr_ptr_r;
                    end
                    if (close_s) begin
                        frame_len_r <= wr_ptr_r + LW'(1);
                        trunc_err_r <= trunc_err_r | ~axis.TLAST;
                    end else begin
                        frame_len_r <= frame_len_r;
                        trunc_err_r <= trunc_err_r;
                    end
                    seq_err_r <= seq_err_r | seq_bad_s;
                end
                FRAME_READY: begin
                    if (pop_s) begin
                        rd_data_r <= mem_r[rd_ptr_r[AW-1:0]];
                        rd_ptr_r  <= rd_ptr_r + LW'(1);
                    end else begin
                        rd_data_r <= rd_data_r;
                        rd_ptr_r  <= rd_ptr_r;
                    end
                end
                default: begin
                    wr_ptr_r <= '0;
                    rd_ptr_r <= '0;
                end
            endcase
        end
    end

    // Frame buffer; contents are don't-care until written, so no reset.
    always_ff @(posedge S_AXIS_ACLK) begin
        if (accept_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= axis.TDATA;
        end else begin
            mem_r[wr_ptr_r[AW-1:0]] <= mem_r[wr_ptr_r[AW-1:0]];
        end
    end

    assign axis.TREADY = tready_r;
    assign frame_done  = frame_done_r;
    assign rd_valid    = rd_valid_r;
    assign rd_data     = rd_data_r;
    assign frame_len   = frame_len_r;
    assign trunc_err   = trunc_err_r;
    assign seq_err     = seq_err_r;
endmodule
